// File: rtl/apb2_master.sv
`default_nettype none
// ============================================================================
// Module      : apb2_master
// Description : APB2 master bridging a valid/ready command channel to an APB
//               bus and returning each transfer result on a valid/ready
//               response channel. One transfer in flight at a time:
//               IDLE -> SETUP -> ACCESS (wait states) -> RESP -> IDLE.
// Options     : APB2_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that
//               sees pready low for TIMEOUT_CYCLES cycles is abandoned and
//               answered with rsp_err=1, rsp_rdata=0.
// Ports       :
//   pclk, preset_n                  clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/addr/wdata/strb/prot  command fields
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              response payload
//   psel, penable, pwrite, paddr,
//   pwdata, pstrb, pprot            APB request
//   prdata, pready, pslverr         APB completion
// Revision    : 1.0 - initial release
// ============================================================================
module apb2_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  // command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  // response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  // APB
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  state_q,     state_d;
  logic                    pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
  logic [DATA_WIDTH/8-1:0] pstrb_q,     pstrb_d;
  logic [2:0]              pprot_q,     pprot_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;

`ifdef APB2_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The final low-pready cycle is the one where the count would reach
  // TIMEOUT_CYCLES, so compare against one less than that.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // cmd_ready is gated by preset_n directly so it is low during reset and
  // rises the moment reset is released, without waiting for a clock edge.
  assign cmd_ready = preset_n && (state_q == ST_IDLE);
  assign psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable   = (state_q == ST_ACCESS);
  assign rsp_valid = (state_q == ST_RESP);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB2_MASTER_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          pprot_d  = cmd_prot;
          state_d  = ST_SETUP;
`ifdef APB2_MASTER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          state_d     = ST_RESP;
        end
`ifdef APB2_MASTER_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= ST_IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB2_MASTER_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB2_MASTER_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb2_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb2_master
// Description : Self-checking bench for apb2_master. Directed transfers plus
//               randomized commands, wait states, slave errors and response
//               back-pressure, checked against expectations derived from
//               the transfer rules (read data or zero, slave error, strobes
//               zeroed on reads, one SETUP then waits+1 ACCESS cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb2_master;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;

  int n_checks = 0;
  int n_errors = 0;

  apb2_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Expected APB request fields of the transfer in flight.
  logic          e_write;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [3:0]    e_strb;
  logic [2:0]    e_prot;

  task automatic check_req(input string tag);
    check({tag, ".psel"},   64'(psel),   64'd1);
    check({tag, ".paddr"},  64'(paddr),  64'(e_addr));
    check({tag, ".pwrite"}, 64'(pwrite), 64'(e_write));
    check({tag, ".pwdata"}, 64'(pwdata), 64'(e_wdata));
    check({tag, ".pstrb"},  64'(pstrb),  64'(e_strb));
    check({tag, ".pprot"},  64'(pprot),  64'(e_prot));
  endtask

  // Present a command at the current (post-edge) time; returns in SETUP.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [3:0] st, input logic [2:0] pr);
    check("idle.cmd_ready", 64'(cmd_ready), 64'd1);
    check("idle.rsp_valid", 64'(rsp_valid), 64'd0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    cmd_strb = st; cmd_prot = pr;
    e_write = wr; e_addr = a; e_wdata = wd; e_strb = wr ? st : 4'h0; e_prot = pr;
    tick();
    cmd_valid = 1'b0;
    cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = $urandom; cmd_strb = ~st;
    check("setup.penable", 64'(penable), 64'd0);
    check("setup.cmd_ready", 64'(cmd_ready), 64'd0);
    check_req("setup");
    // Slave returns during SETUP must be ignored.
    pready = 1'b1; pslverr = 1'b1; prdata = $urandom;
    rsp_ready = 1'($urandom);
  endtask

  // Full transfer: `waits` wait states, then completion with the given
  // slave error/read data, then `hold` cycles of response back-pressure.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input int waits,
                      input logic err, input logic [DW-1:0] rd, input int hold);
    logic [DW-1:0] exp_rd;
    exp_rd = wr ? '0 : rd;
    issue(wr, a, wd, st, pr);
    tick();
    for (int n = 0; n <= waits; n++) begin
      check("access.penable", 64'(penable), 64'd1);
      check_req("access");
      pready  = (n == waits);
      pslverr = (n == waits) ? err : 1'($urandom);
      prdata  = (n == waits) ? rd : DW'($urandom);
      rsp_ready = 1'($urandom);
      tick();
    end
    // Returns outside ACCESS must be ignored.
    pready = 1'($urandom); pslverr = ~err; prdata = ~rd;
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      check("resp.rsp_valid", 64'(rsp_valid), 64'd1);
      check("resp.psel",      64'(psel),      64'd0);
      check("resp.penable",   64'(penable),   64'd0);
      check("resp.cmd_ready", 64'(cmd_ready), 64'd0);
      check("resp.rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
      check("resp.rsp_err",   64'(rsp_err),   64'(err));
      check("resp.paddr",     64'(paddr),     64'(e_addr));
      tick();
    end
    rsp_ready = 1'b0; pready = 1'b0;
    check("post.rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    preset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    e_write = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0; e_prot = '0;
    #23;
    check("rst.cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst.outs", 64'({psel, penable, pwrite, rsp_valid, rsp_err}), 64'd0);
    check("rst.bus", 64'({paddr, pwdata, pstrb, pprot}), 64'd0);
    check("rst.rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(posedge pclk); #1;
    preset_n = 1'b1;
    #1;
    check("rel.cmd_ready", 64'(cmd_ready), 64'd1);

    // Zero-wait write, pready effectively high.
    xfer(1'b1, 8'h00, 32'h1, 4'hF, 3'd0, 0, 1'b0, 32'hDEAD_BEEF, 0);
    // Read with 3 wait states -> 4 ACCESS cycles.
    xfer(1'b0, 8'h00, 32'h0, 4'hF, 3'd2, 3, 1'b0, 32'h1, 0);
    // Slave error on a write, then a clean read.
    xfer(1'b1, 8'h10, 32'hA5A5_5A5A, 4'h3, 3'd1, 1, 1'b1, 32'h0, 0);
    xfer(1'b0, 8'h14, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h1234_5678, 0);
    // Response back-pressure for 5 cycles, then a back-to-back command.
    xfer(1'b0, 8'h20, 32'h0, 4'hF, 3'd7, 2, 1'b0, 32'hCAFE_F00D, 5);
    xfer(1'b1, 8'h24, 32'h7777_0000, 4'hC, 3'd5, 0, 1'b0, 32'h0, 0);

    // Reset during ACCESS: request drops immediately, no response follows.
    issue(1'b1, 8'h33, 32'h3333_3333, 4'hF, 3'd3);
    tick();
    check("rstacc.penable", 64'(penable), 64'd1);
    pready = 1'b0;
    #2;
    preset_n = 1'b0;
    #1;
    check("rstacc.psel",      64'(psel),      64'd0);
    check("rstacc.penable",   64'(penable),   64'd0);
    check("rstacc.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstacc.cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    check("rstacc.hold_rsp", 64'(rsp_valid), 64'd0);
    preset_n = 1'b1;
    #1;
    check("rstacc.rel_ready", 64'(cmd_ready), 64'd1);
    xfer(1'b0, 8'h34, 32'h0, 4'hF, 3'd0, 1, 1'b0, 32'h0BAD_CAFE, 1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      xfer(1'($urandom), AW'($urandom), DW'($urandom), 4'($urandom), 3'($urandom),
           int'($urandom_range(0, 5)), 1'($urandom), DW'($urandom),
           int'($urandom_range(0, 3)));
    end

`ifdef APB2_MASTER_TIMEOUT_EN
    begin
      int acc;
      acc = 0;
      issue(1'b0, 8'h55, 32'h0, 4'hF, 3'd0);
      tick();
      pready = 1'b0; prdata = 32'hFFFF_FFFF;
      while (penable && acc < 100) begin
        acc++;
        tick();
      end
      check("to.access_cycles", 64'(acc), 64'(TO));
      check("to.rsp_valid", 64'(rsp_valid), 64'd1);
      check("to.psel", 64'(psel), 64'd0);
      check("to.rsp_err", 64'(rsp_err), 64'd1);
      check("to.rsp_rdata", 64'(rsp_rdata), 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("to.idle", 64'(cmd_ready), 64'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb2_master.md
APB2_MASTER -- requirements
Module: apb2_master

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of the command write data, pwdata, prdata and rsp_rdata.
REQ-002 Parameter: ADDR_WIDTH, 8, width of cmd_addr and paddr.
REQ-003 Parameter: TIMEOUT_CYCLES, 16, maximum number of pready-low cycles in ACCESS (used only with APB2_MASTER_TIMEOUT_EN).
REQ-004 pclk  in  1  single clock; all state changes on its rising edge.
REQ-005 preset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1  a command is presented.
REQ-007 cmd_ready  out  1  the master accepts a command.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  transfer address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 cmd_strb  in  DATA_WIDTH/8  write byte strobes.
REQ-012 cmd_prot  in  3  protection attributes.
REQ-013 rsp_valid  out  1  a response is available.
REQ-014 rsp_ready  in  1  the response consumer accepts the response.
REQ-015 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-016 rsp_err  out  1  the slave error, or a timeout.
REQ-017 psel, penable, pwrite  out  1 each  APB control signals.
REQ-018 paddr/pwdata/pstrb/pprot  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8/3  APB address, data, strobes and protection.
REQ-019 prdata  in  DATA_WIDTH; pready  in  1; pslverr  in  1  APB slave returns.

Function
REQ-020 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP, with reset state IDLE.
REQ-021 cmd_ready SHALL be 1 only in IDLE with preset_n high.
REQ-022 In IDLE, when cmd_valid and cmd_ready are both high, the master SHALL register all cmd_* fields and move to SETUP.
REQ-023 In SETUP the outputs SHALL be psel=1 and penable=0 for exactly one cycle, then the FSM moves to ACCESS.
REQ-024 In ACCESS the outputs SHALL be psel=1 and penable=1 until pready is sampled high.
  - On that edge: capture pslverr into rsp_err, and prdata into rsp_rdata for reads (0 for writes); move to RESP.
REQ-025 pready high on the first ACCESS cycle SHALL complete the transfer with zero wait states.
REQ-026 paddr, pwrite, pwdata, pstrb and pprot SHALL be stable from SETUP through the last ACCESS cycle.
  - They hold their last values in IDLE and RESP.
  - pstrb SHALL be 0 for reads.
REQ-027 In RESP the outputs SHALL be rsp_valid=1, psel=0 and penable=0.
  - rsp_rdata and rsp_err are held until rsp_valid and rsp_ready are both high.
  - The FSM then returns to IDLE.
REQ-028 rsp_ready is ignored outside RESP; rsp_valid is never high outside RESP.
REQ-029 Minimum command-to-command period SHALL be 4 cycles (IDLE, SETUP, ACCESS, RESP).
  - A new command is accepted on the cycle after the response handshake.
REQ-030 pslverr, prdata and pready SHALL be ignored outside ACCESS.

Reset
REQ-031 While preset_n is low, all outputs SHALL be 0, including cmd_ready.
REQ-032 Assertion of preset_n in any state SHALL immediately force IDLE.
  - psel and penable deassert asynchronously.
  - Any in-flight transfer or pending response is discarded with no rsp_valid.
REQ-033 After preset_n deasserts, cmd_ready SHALL rise in the same cycle, and the first command is accepted on the first rising edge.

Configuration
REQ-034 With APB2_MASTER_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles in which pready is low.
  - The counter resets on entry to SETUP.
  - On the cycle the count reaches TIMEOUT_CYCLES with pready still low, the transfer ends: rsp_err=1, rsp_rdata=0, and the FSM moves to RESP, dropping psel and penable.
REQ-035 Without APB2_MASTER_TIMEOUT_EN, the counter SHALL be absent and ACCESS SHALL wait for pready indefinitely.

Verification
REQ-036 Write cmd addr=0x00, wdata=0x1, strb=0xF, pready tied high -> SETUP 1 cycle with pwdata=0x1, ACCESS 1 cycle, rsp_valid with rsp_err=0 and rsp_rdata=0.
REQ-037 Read addr=0x00, slave returns prdata=0x1 after 3 wait states -> penable high for 4 cycles, rsp_rdata=0x1, paddr stable throughout.
REQ-038 Write with pslverr=1 on the completing ACCESS cycle -> rsp_err=1; a subsequent read completes with rsp_err=0.
REQ-039 Hold rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable for 5 cycles, cmd_ready=0; then IDLE, and a back-to-back command is accepted next cycle.
REQ-040 Assert preset_n low during ACCESS -> psel=0 and penable=0 immediately, no rsp_valid; the next command after release completes normally.
REQ-041 With APB2_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held low -> exactly 16 ACCESS cycles, then rsp_err=1 and rsp_rdata=0.
